// File: rtl/stampflow_pkg.sv
// Shared widths and constants for the instruction-fetch path.
package stampflow_pkg;
   localparam int WORD_W = 88;
   localparam int ADDR_W = 32;
   localparam logic [WORD_W-1:0] NOP_WORD = '0;
endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order response buffer carrying {data, addr, err}.
// Flush drops every held entry but keeps a push that lands on the same edge.
module fetch_skid_buf
   import stampflow_pkg::*;
#(
   parameter int DATA_W = stampflow_pkg::WORD_W,
   parameter int AW     = stampflow_pkg::ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [AW-1:0]     i_in_addr,
   input  logic              i_in_err,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [AW-1:0]     o_out_addr,
   output logic              o_out_err,
   output logic [1:0]        o_count
);
   logic [DATA_W-1:0] r_data [2];
   logic [AW-1:0]     r_addr [2];
   logic              r_err  [2];
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_count;
   logic              w_push;
   logic              w_pop;

   assign o_out_valid = (r_count != 2'd0);
   assign w_pop       = o_out_valid && i_out_ready;
   assign o_in_ready  = (r_count != 2'd2) || w_pop || i_flush;
   assign w_push      = i_in_valid && o_in_ready;
   assign o_out_data  = r_data[r_rd_ptr];
   assign o_out_addr  = r_addr[r_rd_ptr];
   assign o_out_err   = r_err[r_rd_ptr];
   assign o_count     = r_count;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_addr[i] <= '0;
            r_err[i]  <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_data[r_wr_ptr] <= i_in_data;
            r_addr[r_wr_ptr] <= i_in_addr;
            r_err[r_wr_ptr]  <= i_in_err;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         // On flush the head jumps to the write slot, so a same-edge push is the new head.
         if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= {1'b0, w_push};
         end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
         end
      end
   end
endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction store with load port; fetches are read at the accept edge and
// queued in a 2-entry buffer, so a response appears the cycle after acceptance.
module instr_fetch_responder
   import stampflow_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int WORD_W     = stampflow_pkg::WORD_W,
   parameter int ADDR_W     = stampflow_pkg::ADDR_W
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_W-1:0]     i_req_addr,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [WORD_W-1:0]     o_rsp_data,
   output logic [ADDR_W-1:0]     o_rsp_addr,
   output logic                  o_rsp_err,
   input  logic                  i_flush,
   input  logic                  i_load_en,
   input  logic [DEPTH_LOG2-1:0] i_load_addr,
   input  logic [WORD_W-1:0]     i_load_data,
   output logic [1:0]            o_outstanding
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic              w_oor;
   logic [WORD_W-1:0] w_rd_word;
   logic              w_buf_ready;

   // Store is deliberately not reset so preloaded code survives a core reset.
   always_ff @(posedge i_clk) begin
      if (i_load_en) r_mem[i_load_addr] <= i_load_data;
   end

   assign w_oor       = |i_req_addr[ADDR_W-1:DEPTH_LOG2];
   assign w_rd_word   = w_oor ? WORD_W'(NOP_WORD) : r_mem[i_req_addr[DEPTH_LOG2-1:0]];
   assign o_req_ready = i_reset && w_buf_ready;

   fetch_skid_buf #(
      .DATA_W (WORD_W),
      .AW     (ADDR_W)
   ) u_skid (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_flush     (i_flush),
      .i_in_valid  (i_req_valid),
      .o_in_ready  (w_buf_ready),
      .i_in_data   (w_rd_word),
      .i_in_addr   (i_req_addr),
      .i_in_err    (w_oor),
      .o_out_valid (o_rsp_valid),
      .i_out_ready (i_rsp_ready),
      .o_out_data  (o_rsp_data),
      .o_out_addr  (o_rsp_addr),
      .o_out_err   (o_rsp_err),
      .o_count     (o_outstanding)
   );
endmodule

// File: tb/tb_instr_fetch_responder.sv
// Randomized + directed bench: scoreboard queue fed at acceptance, monitor checks at negedge.
module tb_instr_fetch_responder;
   localparam int DL = 8;
   localparam int WW = 88;
   localparam int AW = 32;
   localparam int D  = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          o_req_ready;
   logic [AW-1:0] req_addr;
   logic          o_rsp_valid;
   logic          rsp_ready;
   logic [WW-1:0] o_rsp_data;
   logic [AW-1:0] o_rsp_addr;
   logic          o_rsp_err;
   logic          flush;
   logic          load_en;
   logic [DL-1:0] load_addr;
   logic [WW-1:0] load_data;
   logic [1:0]    o_outstanding;

   always #5 clk = ~clk;

   instr_fetch_responder #(.DEPTH_LOG2(DL), .WORD_W(WW), .ADDR_W(AW)) dut (
      .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(o_req_ready),
      .i_req_addr(req_addr), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_addr(o_rsp_addr), .o_rsp_err(o_rsp_err),
      .i_flush(flush), .i_load_en(load_en), .i_load_addr(load_addr),
      .i_load_data(load_data), .o_outstanding(o_outstanding)
   );

   typedef struct {
      logic [WW-1:0] d;
      logic [AW-1:0] a;
      logic          e;
   } exp_t;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [WW-1:0] m_mem [D];
   exp_t          q[$];
   logic          prev_rst_low = 1'b0;

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Reference: what a fetch of addr returns given the store as loaded so far.
   function automatic exp_t model(logic [AW-1:0] a);
      exp_t r;
      if (a >= AW'(D)) begin
         r.d = '0; r.a = a; r.e = 1'b1;
      end else begin
         r.d = m_mem[a[DL-1:0]]; r.a = a; r.e = 1'b0;
      end
      return r;
   endfunction

   // Monitor: runs at negedge, before the scoreboard updates for the coming edge.
   always @(negedge clk) begin
      if (prev_rst_low) begin
         chk("rst_valid", 128'(o_rsp_valid), 128'(0));
         chk("rst_data", 128'(o_rsp_data), 128'(0));
         chk("rst_addr", 128'(o_rsp_addr), 128'(0));
         chk("rst_err", 128'(o_rsp_err), 128'(0));
         chk("rst_outstanding", 128'(o_outstanding), 128'(0));
      end
      chk("req_ready", 128'(o_req_ready),
          128'(rst && (q.size() < 2 || (o_rsp_valid && rsp_ready) || flush)));
      if (rst && !prev_rst_low) begin
         chk("outstanding", 128'(o_outstanding), 128'(q.size()));
         chk("rsp_valid", 128'(o_rsp_valid), 128'(q.size() != 0));
      end
      if (o_rsp_valid && q.size() != 0) begin
         chk("rsp_data", 128'(o_rsp_data), 128'(q[0].d));
         chk("rsp_addr", 128'(o_rsp_addr), 128'(q[0].a));
         chk("rsp_err", 128'(o_rsp_err), 128'(q[0].e));
         if (rsp_ready) void'(q.pop_front());
      end
      prev_rst_low = !rst;
   end

   // Scoreboard feed: flush/reset clear, accepted fetch pushes, load updates store after.
   always @(negedge clk) begin
      #1;
      if (!rst) q.delete();
      else begin
         if (flush) q.delete();
         if (req_valid && o_req_ready) q.push_back(model(req_addr));
      end
      if (load_en) m_mem[load_addr] = load_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [AW-1:0] a);
      int n = 0;
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      while (!o_req_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) begin
         n_err++;
         $display("FAIL accept_timeout: addr %0h never accepted", a);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic load(input int a, input logic [WW-1:0] d);
      load_en = 1'b1; load_addr = DL'(a); load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   initial begin
      logic [95:0] t;
      rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      @(posedge clk); #1;
      repeat (2) tick();
      rst = 1'b1;

      // Back-to-back fetches of freshly loaded words.
      for (int i = 0; i < 4; i++) load(i, WW'(i + 1));
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) fetch(AW'(i));
      repeat (3) tick();

      // Backpressure: third request must stall at two outstanding.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 0; tick();
      req_addr = 1; tick();
      req_addr = 2; repeat (3) tick();
      @(negedge clk);
      chk("bp_outstanding", 128'(o_outstanding), 128'(2));
      chk("bp_req_ready", 128'(o_req_ready), 128'(0));
      tick();
      rsp_ready = 1'b1;
      fetch(2);
      repeat (4) tick();

      // Out-of-range fetch.
      fetch(300);
      repeat (3) tick();

      // Flush with two outstanding and a same-edge request.
      rsp_ready = 1'b0;
      fetch(0);
      fetch(1);
      flush = 1'b1; req_valid = 1'b1; req_addr = 3;
      tick();
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("flush_outstanding", 128'(o_outstanding), 128'(1));
      chk("flush_head", 128'(o_rsp_data), 128'(88'h4));
      tick();
      rsp_ready = 1'b1;
      repeat (3) tick();

      // Read-before-write on a same-cycle load and fetch.
      load_en = 1'b1; load_addr = 1; load_data = 88'hAA;
      req_valid = 1'b1; req_addr = 1;
      tick();
      load_en = 1'b0; req_valid = 1'b0;
      fetch(1);
      repeat (3) tick();

      // Reset with two outstanding; store must survive.
      rsp_ready = 1'b0;
      fetch(0);
      fetch(2);
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("rstmid_valid", 128'(o_rsp_valid), 128'(0));
      chk("rstmid_req_ready", 128'(o_req_ready), 128'(0));
      chk("rstmid_outstanding", 128'(o_outstanding), 128'(0));
      tick();
      rst = 1'b1;
      rsp_ready = 1'b1;
      fetch(0);
      repeat (3) tick();

      // Randomized traffic over a fully preloaded store.
      for (int i = 0; i < D; i++) begin
         t = {$urandom, $urandom, $urandom};
         load(i, t[WW-1:0]);
      end
      for (int c = 0; c < 3000; c++) begin
         req_valid = ($urandom_range(0, 9) < 7);
         req_addr  = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, D - 1)) : AW'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         load_en   = ($urandom_range(0, 9) == 0);
         load_addr = DL'($urandom_range(0, D - 1));
         t = {$urandom, $urandom, $urandom};
         load_data = t[WW-1:0];
         rst       = ($urandom_range(0, 99) != 0);
         tick();
      end
      rst = 1'b1; req_valid = 1'b0; flush = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      #2;
      chk("drain_empty", 128'(q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Memory-side responder for the CPU instruction-fetch port: accepts word-address fetch requests from the IF stage and returns 88-bit command words with valid/ready flow control, in request order. It sits between the top-level fetch path (PC/`addr_a_read` side) and a simulation/synthesis instruction store. The testbench or a boot loader preloads it through a write port. A flush input discards in-flight fetches on PC redirect.

## Interface
- `DEPTH_LOG2`, default 8: instruction store holds 2**DEPTH_LOG2 words.
- `WORD_W`, default 88: command word width.
- `ADDR_W`, default 32: request address width, word-indexed (one address per command).

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low: sampled `reset==0` at an edge resets.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_addr`  in  ADDR_W  word address to fetch.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_data`  out  WORD_W  fetched command word.
- `rsp_addr`  out  ADDR_W  address that produced `rsp_data`.
- `rsp_err`  out  1  address was out of range.
- `flush`  in  1  discard all outstanding responses.
- `load_en`  in  1  write one word into the store.
- `load_addr`  in  DEPTH_LOG2  store write index.
- `load_data`  in  WORD_W  store write data.
- `outstanding`  out  2  accepted-but-unconsumed responses, 0..2.

## Operation
- Request handshake: accepted when `req_valid && req_ready` at an edge. Response handshake: consumed when `rsp_valid && rsp_ready`.
- `req_ready = reset && (outstanding < 2 || (rsp_valid && rsp_ready) || flush)`.
- Responses are returned strictly in acceptance order. No request is dropped except by flush.
- Range check: `req_addr >= 2**DEPTH_LOG2` gives `rsp_data = 0` (NOP), `rsp_err = 1`, and `rsp_addr = req_addr`. In-range requests give `rsp_err = 0`.
- Store read is synchronous. The store is not reset, and content is undefined until loaded.
- Load and fetch may occur in the same cycle. The fetch returns the old content (read-before-write). The load takes effect for requests accepted on later edges.
- Flush at an edge:
  - All outstanding entries are discarded and `outstanding` becomes 0.
  - `rsp_valid` is 0 in the following cycle.
  - A request accepted on the same edge as the flush is kept. It becomes the sole outstanding entry, with `outstanding = 1`.
- `outstanding` update per edge: +1 on request accept, −1 on response consume, both changes together leave it unchanged. Flush overrides this rule as described above.
- Holding: while `rsp_valid && !rsp_ready`, `rsp_data`, `rsp_addr` and `rsp_err` stay stable.

## Timing
- Reset values, in the cycle after reset is sampled low:
  - `rsp_valid = 0`, `rsp_data = 0`, `rsp_addr = 0`, `rsp_err = 0`, `outstanding = 0`.
  - `req_ready = 0` while `reset == 0`.
- Reset asserted mid-transfer discards all outstanding entries. It has no effect on store contents.
- Latency: a request accepted at edge N with `outstanding == 0` gives `rsp_valid = 1` in cycle N+1.
- Throughput: one response per cycle with `rsp_ready` held high.
- Backpressure: with `rsp_ready` low, at most 2 requests are accepted. `req_ready` then stays 0 until a consume or a flush.

## Structure
- Shared package `stampflow_pkg`: `WORD_W` (88), `ADDR_W` (32), and the `NOP_WORD` constant (all zero).
- Sub-module `fetch_skid_buf`: a 2-entry in-order buffer carrying {data, addr, err}, with valid/ready on both sides and a flush input.
- Top level holds the store array, the range check, the 1-cycle read stage and the `outstanding` counter.

## Test plan
- Load words 0..3 with 88'h1..88'h4, then fetch addresses 0,1,2,3 back-to-back with `rsp_ready = 1` → responses 88'h1..88'h4 in cycles N+1..N+4, `rsp_err = 0`, `outstanding` never exceeds 1.
- `rsp_ready = 0`, requests to addresses 0,1,2 → only 0 and 1 accepted, `req_ready = 0`, `outstanding = 2`. Raise `rsp_ready` → 88'h1 then 88'h2, then address 2 is accepted.
- Fetch address 300 with `DEPTH_LOG2 = 8` → `rsp_data = 0`, `rsp_err = 1`, `rsp_addr = 300`.
- Two outstanding responses plus `flush` together with a new request to address 3 → old entries lost, next response is 88'h4, `outstanding = 1` after the edge.
- Load address 1 with 88'hAA in the same cycle as a fetch of address 1 → response 88'h2. A refetch of address 1 → 88'hAA.
- `reset` low while `outstanding = 2` → next cycle all outputs 0 and `req_ready = 0`. After release, fetch of address 0 returns 88'h1 (store retained).
